// File: rtl/zx_pkg.sv
// zx_pkg -- shared types and decode constants for the Spectrum clock-enable
// and contention logic.
//   machine_t : machine mode selecting the contention rules
//   turbo_t   : CPU enable rate selection
//   phase_t   : two-state CPU clock phase tracker
//   CE_*      : counter patterns decoded into the raw enables
//   turbo_sel : masks and sanitises the raw turbo request
package zx_pkg;

   typedef enum logic [1:0] {
      MODE_48K  = 2'd0,
      MODE_128K = 2'd1,
      MODE_P2A  = 2'd2,
      MODE_NONE = 2'd3
   } machine_t;

   typedef enum logic [1:0] {
      T3M5 = 2'd0,
      T7M0 = 2'd1,
      T14M = 2'd2
   } turbo_t;

   typedef enum logic {
      PH_LOW  = 1'b0,
      PH_HIGH = 1'b1
   } phase_t;

   localparam logic [1:0] CE7_P    = 2'b10;
   localparam logic [1:0] CE7_N    = 2'b00;
   localparam logic [2:0] CE3_P    = 3'b100;
   localparam logic [2:0] CE3_N    = 3'b000;
   // Last clock of a 3.5 MHz period: the only safe point to retime turbo.
   localparam logic [2:0] CE_TLOAD = 3'b111;

   // Reserved encoding 3, or turbo disabled, falls back to 3.5 MHz.
   function automatic turbo_t turbo_sel(input logic [1:0] t, input logic en);
      if (en && (t != 2'd3)) return turbo_t'(t);
      else                   return T3M5;
   endfunction

endpackage

// File: rtl/zx_contend_addr.sv
// zx_contend_addr -- combinational contended-address / ULA-port decode.
//   i_mode    : machine mode
//   i_page    : RAM bank mapped at C000h
//   i_a       : CPU address bus
//   i_mreq    : CPU MREQ, active-low
//   i_iorq    : CPU IORQ, active-low
//   o_cAddr   : access falls in contended memory
//   o_ulaIo   : access is a contended ULA port cycle
module zx_contend_addr
   import zx_pkg::*;
#(
   parameter int unsigned IO_CONTEND = 1
) (
   input  machine_t    i_mode,
   input  logic [2:0]  i_page,
   input  logic [15:0] i_a,
   input  logic        i_mreq,
   input  logic        i_iorq,
   output logic        o_cAddr,
   output logic        o_ulaIo
);

   logic [1:0] w_seg;
   logic       w_lowBank;
   logic       w_unused_bits;

   assign w_seg         = i_a[15:14];
   assign w_lowBank     = (w_seg == 2'b01);
   assign w_unused_bits = ^{i_page[1], i_a[13:1]};

   always_comb begin
      o_cAddr = 1'b0;
      case (i_mode)
         MODE_48K:  o_cAddr = w_lowBank;
         MODE_128K: o_cAddr = w_lowBank | ((w_seg == 2'b11) & i_page[0]);
         // +2A/+3 only contends real memory cycles.
         MODE_P2A:  o_cAddr = (w_lowBank | ((w_seg == 2'b11) & i_page[2])) & ~i_mreq;
         default:   o_cAddr = 1'b0;
      endcase
   end

   assign o_ulaIo = (IO_CONTEND != 0) &&
                    ((i_mode == MODE_48K) || (i_mode == MODE_128K)) &&
                    !i_iorq && !i_a[0];

endmodule

// File: rtl/zx_contention.sv
// zx_contention -- 28 MHz clock-enable generator with VDU contention,
// CPU turbo selection and power-on ready stretch.
//   clock   : 28 MHz system clock
//   reset   : asynchronous active-low reset
//   mode    : 0=48K 1=128K 2=+2A/+3 3=no contention
//   turbo   : 0=3.5 1=7 2=14 MHz, 3 treated as 0
//   page    : RAM bank at C000h
//   vduCn   : VDU display-fetch window
//   mreq    : CPU MREQ (active-low)
//   iorq    : CPU IORQ (active-low)
//   a       : CPU address
//   ce7M0p/n, ce3M5p/n : raw enables
//   cc3M5p/n           : CPU enables after turbo and contention
//   stall   : CPU clock held
//   pwrOn   : power-on ready
module zx_contention
   import zx_pkg::*;
#(
   parameter int unsigned TURBO_EN   = 1,
   parameter int unsigned IO_CONTEND = 1,
   parameter int unsigned PWR_TICKS  = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  mode,
   input  logic [1:0]  turbo,
   input  logic [2:0]  page,
   input  logic        vduCn,
   input  logic        mreq,
   input  logic        iorq,
   input  logic [15:0] a,
   output logic        ce7M0p,
   output logic        ce7M0n,
   output logic        ce3M5p,
   output logic        ce3M5n,
   output logic        cc3M5p,
   output logic        cc3M5n,
   output logic        stall,
   output logic        pwrOn
);

   localparam logic [7:0] PWR_MAX = PWR_TICKS[7:0];

   logic [3:0] r_ce;
   phase_t     r_phase;
   phase_t     w_phase_nxt;
   logic       r_idle;
   turbo_t     r_turboQ;
   logic [7:0] r_pwr;

   machine_t   w_mode;
   logic       w_cAddr, w_ulaIo;
   logic       w_ce7p, w_ce7n, w_ce3p, w_ce3n;
   logic       w_phHigh, w_stall;
   logic       w_ccp, w_ccn;

   assign w_mode = machine_t'(mode);

   zx_contend_addr #(.IO_CONTEND(IO_CONTEND)) u_addr (
      .i_mode  (w_mode),
      .i_page  (page),
      .i_a     (a),
      .i_mreq  (mreq),
      .i_iorq  (iorq),
      .o_cAddr (w_cAddr),
      .o_ulaIo (w_ulaIo)
   );

   assign w_ce7p = (r_ce[1:0] == CE7_P);
   assign w_ce7n = (r_ce[1:0] == CE7_N);
   assign w_ce3p = (r_ce[2:0] == CE3_P);
   assign w_ce3n = (r_ce[2:0] == CE3_N);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_ce <= '0;
      else        r_ce <= r_ce + 4'd1;
   end

   // Phase tracker: state register / next state / output decode.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_phase <= PH_LOW;
      else        r_phase <= w_phase_nxt;
   end

   // Toggles every 7 MHz negative enable, but a stalled HIGH phase is held
   // so the suppressed positive edge is retried on the next 3.5 MHz slot.
   always_comb begin
      w_phase_nxt = r_phase;
      if (w_ce7n)
         w_phase_nxt = ((r_phase == PH_HIGH) && !w_stall) ? PH_LOW : PH_HIGH;
   end

   always_comb w_phHigh = (r_phase == PH_HIGH);

   assign w_stall = vduCn & w_phHigh & r_idle & (w_cAddr | w_ulaIo) &
                    (w_mode != MODE_NONE) & (r_turboQ == T3M5);

   // idle captures whether the CPU was between requests at the T2/Tw3
   // sample point; it is frozen while stalled so the stall cannot
   // release itself.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                 r_idle <= 1'b1;
      else if (w_ce3p && !w_stall) r_idle <= mreq & ~w_ulaIo;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                      r_turboQ <= T3M5;
      else if (r_ce[2:0] == CE_TLOAD)  r_turboQ <= turbo_sel(turbo, TURBO_EN != 0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                           r_pwr <= '0;
      else if (w_ce3p && (r_pwr != PWR_MAX)) r_pwr <= r_pwr + 8'd1;
   end

   always_comb begin
      w_ccp = 1'b0;
      w_ccn = 1'b0;
      case (r_turboQ)
         T3M5: begin w_ccp = w_ce3p & ~w_stall; w_ccn = w_ce3n & ~w_stall; end
         T7M0: begin w_ccp = w_ce7p;            w_ccn = w_ce7n;            end
         T14M: begin w_ccp = r_ce[0];           w_ccn = ~r_ce[0];          end
         default: begin w_ccp = 1'b0;           w_ccn = 1'b0;              end
      endcase
   end

   // Gate with reset so nothing pulses while held in reset (ce = 0 would
   // otherwise decode as a negative enable).
   assign ce7M0p = w_ce7p  & reset;
   assign ce7M0n = w_ce7n  & reset;
   assign ce3M5p = w_ce3p  & reset;
   assign ce3M5n = w_ce3n  & reset;
   assign cc3M5p = w_ccp   & reset;
   assign cc3M5n = w_ccn   & reset;
   assign stall  = w_stall & reset;
   assign pwrOn  = (r_pwr == PWR_MAX);

endmodule

// File: tb/tb_zx_contention.sv
module tb_zx_contention;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  mode  = 2'd3;
   logic [1:0]  turbo = 2'd0;
   logic [2:0]  page  = 3'd0;
   logic        vduCn = 1'b0;
   logic        mreq  = 1'b1;
   logic        iorq  = 1'b1;
   logic [15:0] a     = 16'h0000;

   logic m7p, m7n, m3p, m3n, mcp, mcn, mst, mpo;
   logic l7p, l7n, l3p, l3n, lcp, lcn, lst, lpo;
   logic [7:0] dv0, dv1;
   // {ce7M0p, ce7M0n, ce3M5p, ce3M5n, cc3M5p, cc3M5n, stall, pwrOn}
   assign dv0 = {m7p, m7n, m3p, m3n, mcp, mcn, mst, mpo};
   assign dv1 = {l7p, l7n, l3p, l3n, lcp, lcn, lst, lpo};

   zx_contention u_main (
      .clock(clock), .reset(reset), .mode(mode), .turbo(turbo), .page(page),
      .vduCn(vduCn), .mreq(mreq), .iorq(iorq), .a(a),
      .ce7M0p(m7p), .ce7M0n(m7n), .ce3M5p(m3p), .ce3M5n(m3n),
      .cc3M5p(mcp), .cc3M5n(mcn), .stall(mst), .pwrOn(mpo));

   zx_contention #(.TURBO_EN(0), .IO_CONTEND(0), .PWR_TICKS(2)) u_alt (
      .clock(clock), .reset(reset), .mode(mode), .turbo(turbo), .page(page),
      .vduCn(vduCn), .mreq(mreq), .iorq(iorq), .a(a),
      .ce7M0p(l7p), .ce7M0n(l7n), .ce3M5p(l3p), .ce3M5n(l3n),
      .cc3M5p(lcp), .cc3M5n(lcn), .stall(lst), .pwrOn(lpo));

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: clocks elapsed since reset release plus the few
   // state bits the behaviour rules mention, per instance.
   int p_io[2] = '{1, 0};
   int p_te[2] = '{1, 0};
   int p_pt[2] = '{32, 2};
   int m_n[2], m_tq[2], m_pw[2];
   bit m_ph[2], m_idl[2];
   int s_n;
   logic [7:0] s0, s1;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s n=%0d actual=%b required=%b", nm, s_n, act, exp);
      end
   endtask

   function automatic bit mdl_ula(input int k);
      int aa;
      aa = int'(a);
      return p_io[k] != 0 && mode < 2 && iorq == 1'b0 && (aa % 2) == 0;
   endfunction

   function automatic bit mdl_addr();
      int seg;
      seg = int'(a) / 16384;
      case (mode)
         2'd0: return seg == 1;
         2'd1: return seg == 1 || (seg == 3 && (page % 2) == 1);
         2'd2: return (seg == 1 || (seg == 3 && page >= 4)) && mreq == 1'b0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit mdl_stall(input int k);
      return vduCn && m_ph[k] && m_idl[k] && (mdl_addr() || mdl_ula(k)) &&
             mode != 2'd3 && m_tq[k] == 0;
   endfunction

   function automatic logic [7:0] mdl_eval(input int k);
      int e;
      bit c7p, c7n, c3p, c3n, cp, cn, st;
      if (!reset) return 8'h00;
      e   = m_n[k] % 16;
      c7p = (e % 4) == 2;
      c7n = (e % 4) == 0;
      c3p = (e % 8) == 4;
      c3n = (e % 8) == 0;
      st  = mdl_stall(k);
      if (m_tq[k] == 1)      begin cp = c7p;            cn = c7n;            end
      else if (m_tq[k] == 2) begin cp = (e % 2) == 1;   cn = (e % 2) == 0;   end
      else                   begin cp = c3p && !st;     cn = c3n && !st;     end
      return {c7p, c7n, c3p, c3n, cp, cn, st, m_pw[k] >= p_pt[k]};
   endfunction

   task automatic mdl_step(input int k);
      int e;
      bit st, ula;
      if (!reset) begin
         m_n[k] = 0; m_ph[k] = 0; m_idl[k] = 1; m_tq[k] = 0; m_pw[k] = 0;
      end else begin
         e   = m_n[k] % 16;
         st  = mdl_stall(k);
         ula = mdl_ula(k);
         if ((e % 8) == 4 && !st) m_idl[k] = mreq && !ula;
         if ((e % 4) == 0)        m_ph[k]  = !(m_ph[k] && !st);
         if ((e % 8) == 7)        m_tq[k]  = (p_te[k] != 0 && turbo != 2'd3) ? int'(turbo) : 0;
         if ((e % 8) == 4 && m_pw[k] < p_pt[k]) m_pw[k]++;
         m_n[k]++;
      end
   endtask

   // One clock: sample at negedge, compare both instances to the model,
   // advance the model, return just after the next posedge.
   task automatic cyc();
      @(negedge clock);
      s_n = m_n[0];
      s0  = dv0;
      s1  = dv1;
      chk("model_main", s0, mdl_eval(0));
      chk("model_alt",  s1, mdl_eval(1));
      mdl_step(0);
      mdl_step(1);
      @(posedge clock);
      #1;
   endtask

   task automatic rst_pulse();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   typedef struct {
      logic [1:0]  md;
      logic [2:0]  pg;
      logic [15:0] ad;
      logic        mq, iq, vd;
      logic        st_main, st_alt;
   } vec_t;

   vec_t vt[13];

   initial begin
      vt[0]  = '{2'd0, 3'd0, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vt[1]  = '{2'd0, 3'd0, 16'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{2'd1, 3'd3, 16'hC000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vt[3]  = '{2'd1, 3'd2, 16'hC000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{2'd2, 3'd4, 16'hC000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vt[5]  = '{2'd2, 3'd4, 16'hC000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{2'd2, 3'd0, 16'h00FE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[7]  = '{2'd0, 3'd0, 16'h80FE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[8]  = '{2'd1, 3'd0, 16'h00FE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[9]  = '{2'd3, 3'd0, 16'h4000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[10] = '{2'd0, 3'd0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[11] = '{2'd1, 3'd1, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vt[12] = '{2'd0, 3'd0, 16'h80FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

      for (int k = 0; k < 2; k++) begin
         m_n[k] = 0; m_ph[k] = 0; m_idl[k] = 1; m_tq[k] = 0; m_pw[k] = 0;
      end
      #1;
      cyc();
      chk("reset_main", s0, 8'h00);
      chk("reset_alt",  s1, 8'h00);

      // Table: fresh reset, first phase-high clock (n=1) and the first
      // 3.5 MHz positive slot (n=4) decide the stall.
      for (int v = 0; v < 13; v++) begin
         mode = vt[v].md; page = vt[v].pg; a = vt[v].ad;
         mreq = vt[v].mq; iorq = vt[v].iq; vduCn = vt[v].vd; turbo = 2'd0;
         rst_pulse();
         cyc();
         cyc();
         chk($sformatf("tbl%0d_stall_main", v), {7'd0, s0[1]}, {7'd0, vt[v].st_main});
         chk($sformatf("tbl%0d_stall_alt",  v), {7'd0, s1[1]}, {7'd0, vt[v].st_alt});
         cyc(); cyc(); cyc();
         chk($sformatf("tbl%0d_cc_main", v), {7'd0, s0[3]}, {7'd0, ~vt[v].st_main});
      end

      // Power-on stretch and uncontended pattern.
      mode = 2'd3; turbo = 2'd0; vduCn = 1'b1; a = 16'h4000;
      rst_pulse();
      for (int i = 0; i < 262; i++) begin
         cyc();
         chk("pwr_main", {7'd0, s0[0]}, {7'd0, 1'(i >= 253)});
         chk("pwr_alt",  {7'd0, s1[0]}, {7'd0, 1'(i >= 13)});
         chk("ce3_period", {7'd0, s0[5]}, {7'd0, 1'(i % 8 == 4)});
         chk("cc_eq_ce", {6'd0, s0[3], s0[1]}, {6'd0, s0[5], 1'b0});
      end

      // Turbo change mid-period.
      rst_pulse();
      for (int i = 0; i < 5; i++) cyc();
      turbo = 2'd2;
      for (int i = 5; i < 25; i++) begin
         cyc();
         chk("turbo_ccp_main", {7'd0, s0[3]}, {7'd0, 1'(i >= 8 && i % 2 == 1)});
         chk("turbo_ccp_alt",  {7'd0, s1[3]}, {7'd0, 1'(i % 8 == 4)});
      end
      turbo = 2'd0;

      // Stall held, then released by vduCn falling.
      mode = 2'd0; a = 16'h4000; mreq = 1'b1; iorq = 1'b1; vduCn = 1'b1;
      rst_pulse();
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (i == 4) chk("stall_cc_supp", {6'd0, s0[3], s0[1]}, 8'b01);
         if (i == 8) chk("stall_held", {7'd0, s0[1]}, 8'd1);
      end
      vduCn = 1'b0;
      cyc();
      chk("vdu_release", {7'd0, s0[1]}, 8'd0);
      cyc();
      cyc();
      chk("next_ccp_passes", {7'd0, s0[3]}, 8'd1);

      // Asynchronous reset while stalled.
      vduCn = 1'b1;
      rst_pulse();
      for (int i = 0; i < 20; i++) cyc();
      chk("pre_rst_stall", {6'd0, dv0[1], dv1[0]}, 8'b11);
      reset = 1'b0;
      #1;
      chk("async_rst_main", dv0, 8'h00);
      chk("async_rst_alt",  dv1, 8'h00);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      chk("post_rst_n0", s0, 8'b01010100);
      for (int i = 0; i < 4; i++) cyc();

      // Randomised traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 6))
               0: a = 16'h4000;
               1: a = 16'hC000;
               2: a = 16'h80FE;
               3: a = 16'h00FE;
               4: a = 16'h8000;
               5: a = 16'h7FFF;
               default: a = 16'($urandom);
            endcase
         end
         if ($urandom_range(0, 7) == 0)  mode  = 2'($urandom);
         if ($urandom_range(0, 15) == 0) turbo = 2'($urandom);
         if ($urandom_range(0, 3) == 0)  vduCn = 1'($urandom);
         if ($urandom_range(0, 3) == 0)  mreq  = 1'($urandom);
         if ($urandom_range(0, 3) == 0)  iorq  = 1'($urandom);
         if ($urandom_range(0, 7) == 0)  page  = 3'($urandom);
         if (!reset)                              reset = 1'b1;
         else if ($urandom_range(0, 599) == 0)    reset = 1'b0;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
